// File: rtl/sdram_pkg.sv
// sdram_pkg: definitions shared by the wb_sdram slave stages.
// Word width and the read-buffer bus FSM encoding.
package sdram_pkg;

    localparam int SDRAM_WORD_W = 32;

    typedef enum logic {
        RB_IDLE = 1'b0,
        RB_ACK  = 1'b1
    } rb_state_t;

endpackage

// File: rtl/sdram_fifo_ram.sv
// sdram_fifo_ram: DEPTH x DATA_WIDTH register array.
// One synchronous write port, one asynchronous read port.
module sdram_fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    // Write the pushed word into its slot.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sdram_read_buffer.sv
// sdram_read_buffer: read-engine FIFO drained by a Wishbone
// classic read-only slave, with almost-full, flush and overflow.
module sdram_read_buffer
    import sdram_pkg::*;
#(
    parameter int DATA_WIDTH = SDRAM_WORD_W,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_MARGIN  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_wr,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_full,
    input  logic                  flush,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    output logic [DATA_WIDTH-1:0] wbs_dat_o,
    output logic                  wbs_ack_o,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  overflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] C_DEPTH =
        (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] C_AF_LVL =
        (ADDR_WIDTH+1)'(DEPTH - AF_MARGIN);

    rb_state_t               r_state;
    rb_state_t               w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_wr_ptr;
    logic [ADDR_WIDTH-1:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]     r_count;
    logic                    r_ovf;
    logic [DATA_WIDTH-1:0]   r_dat;
    logic [DATA_WIDTH-1:0]   w_rdata;
    logic                    w_clr;
    logic                    w_req;
    logic                    w_empty;
    logic                    w_is_full;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;

    assign w_clr     = rst | flush;
    assign w_req     = wbs_cyc_i & wbs_stb_i;
    assign w_empty   = (r_count == '0);
    assign w_is_full = (r_count == C_DEPTH);

    // A pop frees a slot first, so a push into a full
    // buffer is still accepted when a read lands with it.
    assign w_push = fifo_wr & ~w_clr & (~w_is_full | w_pop);
    assign w_drop = fifo_wr & ~w_clr & w_is_full & ~w_pop;

    sdram_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (fifo_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    // Bus FSM next state and pop decision.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        unique case (r_state)
            RB_IDLE: begin
                if (w_req) begin
                    if (wbs_we_i) begin
                        w_state_nxt = RB_ACK;
                    end else if (!w_empty) begin
                        w_state_nxt = RB_ACK;
                        w_pop       = ~w_clr;
                    end
                end
            end
            RB_ACK: begin
                w_state_nxt = RB_IDLE;
            end
            default: begin
                w_state_nxt = RB_IDLE;
            end
        endcase
    end

    // Bus FSM state register; flush and reset abort any ack.
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_state <= RB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Read data register, loaded with the popped word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dat <= '0;
        end else if (w_pop) begin
            r_dat <= w_rdata;
        end
    end

    assign wbs_ack_o = (r_state == RB_ACK);
    assign wbs_dat_o = r_dat;
    assign count     = r_count;
    assign empty     = w_empty;
    assign overflow  = r_ovf;
    assign fifo_full = (r_count >= C_AF_LVL);

endmodule

// File: tb/tb_sdram_read_buffer.sv
// tb_sdram_read_buffer: vector table, directed corner cases
// and random traffic against a queue-based reference model.
module tb_sdram_read_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_wr;
    logic [31:0] fifo_data;
    logic        fifo_full;
    logic        flush;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic [4:0]  count;
    logic        empty;
    logic        overflow;

    always #5 clk = ~clk;

    sdram_read_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_wr   (fifo_wr),
        .fifo_data (fifo_data),
        .fifo_full (fifo_full),
        .flush     (flush),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_dat_o (wbs_dat_o),
        .wbs_ack_o (wbs_ack_o),
        .count     (count),
        .empty     (empty),
        .overflow  (overflow)
    );

    int n_pass = 0;
    int n_chk  = 0;
    int maxc   = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference model: a queue of at most 16 words.
    logic [31:0] mq[$];
    bit          m_ack = 0;
    bit          m_ovf = 0;
    logic [31:0] m_dat = 0;
    bit          m_dchk;

    task automatic step(input bit wr, input logic [31:0] d,
                        input bit rq, input bit we,
                        input bit fl, input bit rs);
        bit nack;
        fifo_wr   = wr;
        fifo_data = d;
        wbs_cyc_i = rq;
        wbs_stb_i = rq;
        wbs_we_i  = we;
        flush     = fl;
        rst       = rs;
        nack   = 0;
        m_dchk = 0;
        if (rs || fl) begin
            mq.delete();
            m_ovf = 0;
            m_ack = 0;
            if (rs) begin
                m_dat  = 0;
                m_dchk = 1;
            end
        end else begin
            if (rq && !m_ack) begin
                if (we) nack = 1;
                else if (mq.size() > 0) begin
                    m_dat  = mq.pop_front();
                    nack   = 1;
                    m_dchk = 1;
                end
            end
            if (wr) begin
                if (mq.size() < 16) mq.push_back(d);
                else m_ovf = 1;
            end
            m_ack = nack;
        end
        @(posedge clk);
        #1;
        if (int'(count) > maxc) maxc = int'(count);
        chk("m_count", 64'(count), 64'(mq.size()));
        chk("m_ack", 64'(wbs_ack_o), 64'(m_ack));
        chk("m_ovf", 64'(overflow), 64'(m_ovf));
        chk("m_full", 64'(fifo_full), 64'(mq.size() >= 14));
        chk("m_empty", 64'(empty), 64'(mq.size() == 0));
        if (m_dchk) chk("m_dat", 64'(wbs_dat_o), 64'(m_dat));
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] d;
        bit          rq;
        bit          we;
        logic [4:0]  cnt;
        bit          ack;
        logic [31:0] dat;
        bit          full;
        bit          emp;
    } vec_t;

    vec_t tv[15];

    initial begin
        logic [31:0] got[$];
        logic [31:0] last;
        int          acks;

        tv[0]  = '{1, 32'hA5A50001, 0, 0, 5'd1, 0, 32'h0, 0, 0};
        tv[1]  = '{1, 32'hA5A50002, 0, 0, 5'd2, 0, 32'h0, 0, 0};
        tv[2]  = '{1, 32'hA5A50003, 0, 0, 5'd3, 0, 32'h0, 0, 0};
        tv[3]  = '{0, 32'h0, 1, 0, 5'd2, 1, 32'hA5A50001, 0, 0};
        tv[4]  = '{0, 32'h0, 0, 0, 5'd2, 0, 32'h0, 0, 0};
        tv[5]  = '{0, 32'h0, 1, 0, 5'd1, 1, 32'hA5A50002, 0, 0};
        tv[6]  = '{0, 32'h0, 0, 0, 5'd1, 0, 32'h0, 0, 0};
        tv[7]  = '{0, 32'h0, 1, 0, 5'd0, 1, 32'hA5A50003, 0, 1};
        tv[8]  = '{0, 32'h0, 0, 0, 5'd0, 0, 32'h0, 0, 1};
        tv[9]  = '{0, 32'h0, 1, 0, 5'd0, 0, 32'h0, 0, 1};
        tv[10] = '{1, 32'hDEADBEEF, 1, 0, 5'd1, 0, 32'h0, 0, 0};
        tv[11] = '{0, 32'h0, 1, 0, 5'd0, 1, 32'hDEADBEEF, 0, 1};
        tv[12] = '{1, 32'h5, 0, 0, 5'd1, 0, 32'h0, 0, 0};
        tv[13] = '{0, 32'h0, 1, 1, 5'd1, 1, 32'h0, 0, 0};
        tv[14] = '{0, 32'h0, 0, 0, 5'd1, 0, 32'h0, 0, 0};

        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("rst_full", 64'(fifo_full), 0);
        chk("rst_empty", 64'(empty), 1);
        chk("rst_count", 64'(count), 0);
        chk("rst_ovf", 64'(overflow), 0);
        chk("rst_ack", 64'(wbs_ack_o), 0);
        chk("rst_dat", 64'(wbs_dat_o), 0);
        step(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 15; i++) begin
            step(tv[i].wr, tv[i].d, tv[i].rq, tv[i].we, 0, 0);
            chk($sformatf("tv%0d_count", i), 64'(count),
                64'(tv[i].cnt));
            chk($sformatf("tv%0d_ack", i), 64'(wbs_ack_o),
                64'(tv[i].ack));
            chk($sformatf("tv%0d_full", i), 64'(fifo_full),
                64'(tv[i].full));
            chk($sformatf("tv%0d_empty", i), 64'(empty),
                64'(tv[i].emp));
            if (tv[i].ack && !tv[i].we)
                chk($sformatf("tv%0d_dat", i), 64'(wbs_dat_o),
                    64'(tv[i].dat));
        end

        // Almost-full, then overflow on the 17th push.
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 13; i++) step(1, 32'h200 + i, 0, 0, 0, 0);
        chk("af_13_full", 64'(fifo_full), 0);
        step(1, 32'h20D, 0, 0, 0, 0);
        chk("af_14_full", 64'(fifo_full), 1);
        chk("af_14_count", 64'(count), 14);
        step(1, 32'h20E, 0, 0, 0, 0);
        step(1, 32'h20F, 0, 0, 0, 0);
        chk("af_16_count", 64'(count), 16);
        chk("af_16_ovf", 64'(overflow), 0);
        step(1, 32'h210, 0, 0, 0, 0);
        chk("af_17_count", 64'(count), 16);
        chk("af_17_ovf", 64'(overflow), 1);

        // Drain to 5, then flush with a same-cycle push.
        for (int i = 0; i < 11; i++) begin
            step(0, 0, 1, 0, 0, 0);
            step(0, 0, 0, 0, 0, 0);
        end
        chk("fl_pre_count", 64'(count), 5);
        step(1, 32'hBAD0BAD0, 0, 0, 1, 0);
        chk("fl_count", 64'(count), 0);
        chk("fl_empty", 64'(empty), 1);
        chk("fl_ovf", 64'(overflow), 0);
        step(0, 0, 1, 0, 0, 0);
        chk("fl_lost", 64'(wbs_ack_o), 0);
        step(0, 0, 0, 0, 0, 0);

        // Empty wait for 10 cycles, then a push releases it.
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 0, 0, 0);
            if (wbs_ack_o) acks++;
        end
        chk("wait_noack", 64'(acks), 0);
        step(1, 32'hDEADBEEF, 1, 0, 0, 0);
        chk("wait_push_ack", 64'(wbs_ack_o), 0);
        step(0, 0, 1, 0, 0, 0);
        chk("wait_ack", 64'(wbs_ack_o), 1);
        chk("wait_dat", 64'(wbs_dat_o), 64'hDEADBEEF);
        step(0, 0, 0, 0, 0, 0);

        // Push and pop together while full.
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 16; i++) step(1, 32'h300 + i, 0, 0, 0, 0);
        step(1, 32'h11111111, 1, 0, 0, 0);
        chk("fpp_ack", 64'(wbs_ack_o), 1);
        chk("fpp_dat", 64'(wbs_dat_o), 64'h300);
        chk("fpp_count", 64'(count), 16);
        chk("fpp_ovf", 64'(overflow), 0);
        step(0, 0, 0, 0, 0, 0);
        last = 0;
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 0, 0, 0);
            if (wbs_ack_o) last = wbs_dat_o;
            step(0, 0, 0, 0, 0, 0);
        end
        chk("fpp_last", 64'(last), 64'h11111111);
        chk("fpp_drained", 64'(count), 0);

        // Wrap-around: 40 push/pop pairs.
        step(0, 0, 0, 0, 1, 0);
        maxc = 0;
        got.delete();
        for (int k = 0; k < 40; k++) begin
            step(1, 32'h1000 + k, 1, 0, 0, 0);
            if (wbs_ack_o) got.push_back(wbs_dat_o);
            step(0, 0, 0, 0, 0, 0);
        end
        step(0, 0, 1, 0, 0, 0);
        if (wbs_ack_o) got.push_back(wbs_dat_o);
        step(0, 0, 0, 0, 0, 0);
        chk("wrap_len", 64'(got.size()), 40);
        for (int k = 0; k < got.size() && k < 40; k++)
            chk($sformatf("wrap_%0d", k), 64'(got[k]),
                64'(32'h1000 + k));
        chk("wrap_max", 64'(maxc <= 16), 1);

        // Reset in the middle of an ack.
        step(1, 32'h77, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("ra_ack", 64'(wbs_ack_o), 1);
        chk("ra_dat", 64'(wbs_dat_o), 64'h77);
        step(0, 0, 0, 0, 0, 1);
        chk("ra_ack_clr", 64'(wbs_ack_o), 0);
        chk("ra_dat_clr", 64'(wbs_dat_o), 0);
        step(0, 0, 0, 0, 0, 0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            bit wr;
            bit rq;
            bit we;
            bit fl;
            int bias;
            bias = ((i / 150) % 2 == 0) ? 70 : 35;
            wr = ($urandom_range(0, 99) < bias);
            rq = ($urandom_range(0, 99) < 50);
            we = ($urandom_range(0, 99) < 10);
            fl = ($urandom_range(0, 199) == 0);
            step(wr, $urandom, rq, we, fl, 0);
        end
        chk("rand_max", 64'(maxc <= 16), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sdram_read_buffer.md
# sdram_read_buffer

Buffers 32-bit words produced by the SDRAM read engine (`fifo_wr`/`fifo_data`/`fifo_full` side) and returns them to the bus through a Wishbone classic read-only slave port. It is the stage directly downstream of the read engine in the wb_sdram slave. It provides early back-pressure (almost-full) so the engine can complete the word already in flight. It also provides flush, occupancy count and a sticky overflow flag.

## Interface
- `DATA_WIDTH`, 32, word width; must match the read engine's `fifo_data`.
- `ADDR_WIDTH`, 4, log2 of the FIFO depth (DEPTH = 16).
- `AF_MARGIN`, 2, free slots still remaining when `fifo_full` asserts; legal range 1..DEPTH-1.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `fifo_wr` in 1: push strobe from the read engine; one word per cycle high.
- `fifo_data` in DATA_WIDTH: push data, sampled when `fifo_wr`=1.
- `fifo_full` out 1: almost-full back-pressure to the read engine.
- `flush` in 1: synchronous discard of all buffered words.
- `wbs_cyc_i` in 1: Wishbone cycle.
- `wbs_stb_i` in 1: Wishbone strobe.
- `wbs_we_i` in 1: Wishbone write enable.
- `wbs_dat_o` out DATA_WIDTH: read data, valid while `wbs_ack_o`=1.
- `wbs_ack_o` out 1: single-cycle acknowledge.
- `count` out ADDR_WIDTH+1: number of buffered words, 0..DEPTH.
- `empty` out 1: `count`==0.
- `overflow` out 1: sticky; set when a push is dropped.

## Operation
- Circular buffer with DEPTH entries, `wr_ptr`/`rd_ptr` of ADDR_WIDTH bits that wrap modulo DEPTH, and a separate `count` register (no pointer-MSB trick).
- Push: when `fifo_wr`=1 and `count`<DEPTH, write `fifo_data` to `mem[wr_ptr]` and increment `wr_ptr`.
- When `fifo_wr`=1 and `count`==DEPTH, drop the word, leave the pointers unchanged and set `overflow`.
- `fifo_full` = (`count` >= DEPTH-AF_MARGIN). It is combinational from the registered `count`.
- `empty` = (`count`==0), combinational from the registered `count`.
- Bus FSM states:
  - IDLE: request = `wbs_cyc_i & wbs_stb_i`.
    - If request and `wbs_we_i`=1: go to ACK with `wbs_ack_o`=1. Write data is ignored and nothing is popped.
    - If request and `wbs_we_i`=0 and not `empty`: go to ACK with `wbs_ack_o`=1, `wbs_dat_o`<=`mem[rd_ptr]`, and pop (`rd_ptr`+1).
    - If request and `wbs_we_i`=0 and `empty`: stay in IDLE. This is the wait state; no ack is issued.
  - ACK: `wbs_ack_o`<=0 and return to IDLE unconditionally. One ack per strobe, so a back-to-back read costs 2 cycles per word.
- `count` update:
  - push only: +1.
  - pop only: −1.
  - push and pop in the same cycle: unchanged. This holds even when `count`==DEPTH, because the pop frees a slot first and the push is accepted.
- `wbs_cyc_i` dropping while in IDLE-wait abandons the request with no side effect.
- `flush`=1 has priority over push, pop and the FSM:
  - `wr_ptr`, `rd_ptr` and `count` go to 0, `overflow` clears, `wbs_ack_o`<=0, FSM goes to IDLE.
  - A same-cycle `fifo_wr` is discarded.
- `rst` behaves like `flush` and additionally clears `wbs_dat_o`.

## Timing
- Reset values: `fifo_full`=0, `empty`=1, `count`=0, `overflow`=0, `wbs_ack_o`=0, `wbs_dat_o`=0.
- Push-to-visibility: a word pushed at edge N updates `count` and `empty` after edge N. A read request present at edge N+1 is acked after edge N+1. Minimum write-to-ack latency is 1 cycle.
- Read latency: a request seen at an edge with the FIFO non-empty gives `wbs_ack_o` and `wbs_dat_o` valid after that same edge, for exactly one cycle.
- `fifo_full` tracks `count` with 0 extra cycles. The upstream engine may issue up to AF_MARGIN pushes after it first sees `fifo_full` without loss.
- The upstream engine drives `fifo_wr`/`fifo_data` from the falling edge. This block samples them on the rising edge; a half-cycle path is accepted.

## Structure
- Shared package `sdram_pkg`: `SDRAM_WORD_W` (32) and the bus FSM state encoding (`RB_IDLE`, `RB_ACK`).
- One sub-module: `sdram_fifo_ram`, a simple dual-port register array (1 write port, 1 read port, DEPTH × DATA_WIDTH) with synchronous write and asynchronous read. Pointers, count, flags and the FSM stay in the top module.

## Test plan
- Basic ordering: after reset, push 0xA5A50001..0xA5A50003. Three Wishbone reads return those words in order. `count` steps 3→0, `empty`=1 at the end.
- Almost-full: push 14 words (DEPTH=16, AF_MARGIN=2) → `fifo_full`=1 after the 14th push. Push 2 more → `count`=16, `overflow`=0. Push a 17th → dropped, `overflow`=1, `count`=16.
- Empty wait: issue a read with the FIFO empty → no ack for 10 cycles. Push 0xDEADBEEF → ack on the next cycle with 0xDEADBEEF.
- Full simultaneous push and pop: with `count`=16, push 0x11111111 and pop in the same cycle → `count`=16, pop returns the oldest word, `overflow` stays 0. After 16 further reads, 0x11111111 is the last word returned.
- Wrap-around: 40 push/pop pairs with incrementing data → returned sequence is identical to the pushed sequence and `count`≤DEPTH throughout.
- Flush and reset mid-operation:
  - Assert `flush` with `count`=5 and `fifo_wr`=1 → `count`=0, `empty`=1, `overflow`=0, pushed word lost.
  - Assert `rst` during an ack cycle → `wbs_ack_o`=0 and `wbs_dat_o`=0 next cycle.
  - A Wishbone write returns a single ack and leaves `count` unchanged.
